// File: rtl/fpcvt_rr_sched_pkg.sv
// Shared constants and types for the round-robin FPCVT scheduler:
// sample/float field widths, result-register state encoding and the float result record.
package fpcvt_rr_sched_pkg;

  localparam int FP_DW = 12;
  localparam int FP_EW = 3;
  localparam int FP_FW = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } st_e;

  typedef struct packed {
    logic             s;
    logic [FP_EW-1:0] e;
    logic [FP_FW-1:0] f;
  } fp_t;

endpackage

// File: rtl/fpcvt_rr_sched_fpcvt.sv
// Combinational 12-bit two's complement to sign/exponent/significand converter.
// Value represented is F * 2^E, rounded half-up, saturating at E=7 F=4'hF.
module fpcvt
  import fpcvt_rr_sched_pkg::*;
(
  input  logic [FP_DW-1:0] i_d,
  output fp_t              o_fp
);

  logic [FP_DW-1:0] w_mag;
  logic [FP_EW-1:0] w_e;
  logic [FP_FW:0]   w_shx;
  logic [FP_FW:0]   w_sum;

  // magnitude and exponent taken from the position of the leading one
  always_comb begin
    w_mag = i_d[FP_DW-1] ? (~i_d + 12'd1) : i_d;
    w_e   = 3'd0;
    for (int p = 4; p <= 10; p++) begin
      if (w_mag[p]) begin
        w_e = 3'(p - 3);
      end else begin
        w_e = w_e;
      end
    end
  end

  // w_shx holds the four significand bits plus the first dropped bit for rounding
  assign w_shx = 5'({w_mag, 1'b0} >> w_e);
  assign w_sum = {1'b0, w_shx[4:1]} + {4'd0, w_shx[0]};

  // rounding carry bumps the exponent; at the top exponent it saturates instead
  always_comb begin
    o_fp.s = i_d[FP_DW-1];
    if (w_mag[FP_DW-1]) begin
      o_fp.e = 3'd7;
      o_fp.f = 4'hF;
    end else if (w_sum[FP_FW]) begin
      if (w_e == 3'd7) begin
        o_fp.e = 3'd7;
        o_fp.f = 4'hF;
      end else begin
        o_fp.e = w_e + 3'd1;
        o_fp.f = 4'h8;
      end
    end else begin
      o_fp.e = w_e;
      o_fp.f = w_sum[FP_FW-1:0];
    end
  end

endmodule

// File: rtl/fpcvt_rr_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// ascending with wrap. Produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx
);

  // scan NREQ positions starting at the pointer, keep the first hit
  always_comb begin
    logic         found;
    logic [IDW:0] idx;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, i_ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end else begin
        idx = idx;
      end
      if (!found && i_req[idx[IDW-1:0]]) begin
        found                   = 1'b1;
        o_gnt[idx[IDW-1:0]]     = 1'b1;
        o_gnt_idx               = idx[IDW-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fpcvt_rr_sched.sv
// Round-robin scheduler sharing one FPCVT converter among NREQ requesters,
// with a single-entry valid/ready result stage and a saturating delivery counter.
module fpcvt_rr_sched
  import fpcvt_rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*FP_DW-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDW-1:0]        out_id,
  output logic                  out_S,
  output logic [FP_EW-1:0]      out_E,
  output logic [FP_FW-1:0]      out_F,
  output logic [CNTW-1:0]       conv_cnt
);

  st_e              r_state;
  st_e              w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  fp_t              r_fp;
  logic [CNTW-1:0]  r_cnt;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_idx;
  logic [FP_DW-1:0] w_mux_d;
  fp_t              w_fp;
  logic             w_can_acc;
  logic             w_accept;
  logic             w_drain;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_idx(w_gnt_idx)
  );

  assign w_mux_d = req_data[int'(w_gnt_idx)*FP_DW +: FP_DW];

  fpcvt u_cvt (
    .i_d (w_mux_d),
    .o_fp(w_fp)
  );

  // result-register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: a drain paired with a fresh accept keeps the stage full
  always_comb begin
    case (r_state)
      ST_EMPTY: w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
      ST_FULL:  w_state_nxt = (w_drain && !w_accept) ? ST_EMPTY : ST_FULL;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // handshake decode; rst_n gating keeps req_ready low throughout reset
  always_comb begin
    w_can_acc = (r_state == ST_EMPTY) || out_ready;
    w_accept  = rst_n && w_can_acc && (|w_gnt);
    w_drain   = (r_state == ST_FULL) && out_ready;
    req_ready = w_accept ? w_gnt : '0;
  end

  // round-robin pointer moves past the winner only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : (w_gnt_idx + IDW'(1));
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // result register, loaded with the converter output of the granted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
      r_fp <= '0;
    end else if (w_accept) begin
      r_id <= w_gnt_idx;
      r_fp <= w_fp;
    end else begin
      r_id <= r_id;
      r_fp <= r_fp;
    end
  end

  // delivered-result counter, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + CNTW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_id    = r_id;
  assign out_S     = r_fp.s;
  assign out_E     = r_fp.e;
  assign out_F     = r_fp.f;
  assign conv_cnt  = r_cnt;

endmodule

// File: tb/tb_fpcvt_rr_sched.sv
// Directed plus randomized bench for fpcvt_rr_sched against an arithmetic reference model.
module tb_fpcvt_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [47:0]     req_data;
  logic [3:0]      req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_id;
  logic            out_S;
  logic [2:0]      out_E;
  logic [3:0]      out_F;
  logic [3:0]      conv_cnt;

  int checks = 0;
  int errors = 0;

  int         m_ptr;
  bit         m_valid;
  int         m_id;
  logic [7:0] m_res;
  int         m_cnt;

  always #5 clk = ~clk;

  fpcvt_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id   (out_id),
    .out_S    (out_S),
    .out_E    (out_E),
    .out_F    (out_F),
    .conv_cnt (conv_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // smallest exponent whose half-up rounded quotient fits in four bits
  function automatic logic [7:0] ref_cvt(input logic [11:0] d);
    int v, mag, f;
    v   = int'($signed(d));
    mag = (v < 0) ? -v : v;
    if (mag >= 2048) return {1'b1, 3'd7, 4'hF};
    for (int e = 0; e < 8; e++) begin
      f = (e == 0) ? mag : ((mag + (1 << (e - 1))) >> e);
      if (f <= 15) return {d[11], 3'(e), 4'(f)};
    end
    return {d[11], 3'd7, 4'hF};
  endfunction

  function automatic int ref_grant();
    if (m_valid && !out_ready) return -1;
    for (int j = 0; j < NREQ; j++) begin
      if (req_valid[(m_ptr + j) % NREQ]) return (m_ptr + j) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = 8'h00; m_cnt = 0;
  endtask

  // one clock: check req_ready, advance model over the edge, check outputs
  task automatic cycle(output int acc);
    logic [3:0] exp_rdy;
    #1;
    acc     = ref_grant();
    exp_rdy = (acc >= 0) ? (4'b0001 << acc) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_valid && out_ready && m_cnt < CMAX) m_cnt++;
    if (acc >= 0) begin
      m_valid = 1'b1;
      m_id    = acc;
      m_res   = ref_cvt(req_data[acc*12 +: 12]);
      m_ptr   = (acc + 1) % NREQ;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_id", 32'(out_id), 32'(m_id));
      chk("out_sef", 32'({out_S, out_E, out_F}), 32'(m_res));
    end
    chk("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    int         acc;
    logic [11:0] bd [4];
    logic [7:0]  be [4];
    logic [11:0] snap;
    bd = '{12'h800, 12'hFFF, 12'h000, 12'h7FF};
    be = '{8'hFF, 8'h81, 8'h00, 8'h7F};

    // reset with every requester pending
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = {$urandom, $urandom};
    out_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready2", 32'(req_ready), 32'h0);
    chk("rst_conv_cnt", 32'(conv_cnt), 32'h0);
    chk("rst_out_sef", 32'({out_id, out_S, out_E, out_F}), 32'h0);
    rst_n = 1'b1;
    cycle(acc);
    chk("first_grant", 32'(out_id), 32'h0);

    // single requester 2 with a rounding-carry sample
    req_valid = 4'b0100;
    req_data[24 +: 12] = 12'h07D;
    cycle(acc);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_id", 32'(out_id), 32'h2);
    chk("t2_sef", 32'({out_S, out_E, out_F}), 32'h48);

    // bring the pointer back to 0
    req_valid = 4'b1000;
    cycle(acc);

    // all requesters pending: strict rotation with no bubbles
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      cycle(acc);
      chk("t3_id", 32'(out_id), 32'(j % 4));
      chk("t3_valid", 32'(out_valid), 32'h1);
    end

    // stall: outputs frozen, no grants
    out_ready = 1'b0;
    snap = {out_id, out_S, out_E, out_F, 1'b0};
    for (int j = 0; j < 5; j++) begin
      cycle(acc);
      chk("t4_hold", 32'({out_id, out_S, out_E, out_F, 1'b0}), 32'(snap));
      chk("t4_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    cycle(acc);
    cycle(acc);

    // boundary conversions through requester 0
    req_valid = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      req_data[11:0] = bd[j];
      cycle(acc);
      chk("t5_sef", 32'({out_S, out_E, out_F}), 32'(be[j]));
    end

    // reset while a result is held
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_cnt", 32'(conv_cnt), 32'h0);
    chk("t6_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // counter saturation
    for (int j = 0; j < 20; j++) cycle(acc);
    chk("t6_sat", 32'(conv_cnt), 32'(CMAX));

    // randomized traffic obeying the hold-until-ready rule
    req_valid = 4'h0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          req_data[i*12 +: 12] = 12'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc >= 0) req_valid[acc] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
